// File: rtl/mux_scan_ctrl.sv
// Round-robin select driver for a 4:1 byte mux with a double-buffered channel bank.
// Shadow writes are committed to the active bank only on a frame-wrapping tick, so the mux output never tears.
module mux_scan_ctrl #(
  parameter int SIZE_SEL = 2,
  parameter int SIZE_M   = 4,
  parameter int SIZE_N   = 8,
  parameter int DIV      = 50000,
  parameter int DIV_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic [SIZE_SEL-1:0]      wr_addr,
  input  logic [SIZE_N-1:0]        wr_data,
  input  logic                     update,
  input  logic [SIZE_M-1:0]        ch_mask,
  output logic [SIZE_SEL-1:0]      sel,
  output logic [SIZE_M*SIZE_N-1:0] data_bus,
  output logic                     ch_valid,
  output logic                     frame_done,
  output logic                     committed
);

  logic [DIV_W-1:0]    cnt;
  logic [SIZE_N-1:0]   shadow [SIZE_M];
  logic                pending;
  logic                tick;
  logic                any_ch;
  logic                wrap;
  logic                commit;
  logic [SIZE_SEL-1:0] next_sel;
  logic [SIZE_SEL-1:0] cand;
  logic                found;

  assign tick   = en && (cnt == DIV_W'(DIV - 1));
  assign any_ch = |ch_mask;

  // Cyclic search starting at sel+1; the last candidate is sel itself, so a
  // single enabled channel is re-selected on every tick.
  always_comb begin
    next_sel = sel;
    cand     = '0;
    found    = 1'b0;
    for (int k = 1; k <= SIZE_M; k++) begin
      cand = sel + SIZE_SEL'(k);
      if (!found && ch_mask[cand]) begin
        next_sel = cand;
        found    = 1'b1;
      end
    end
  end

  assign wrap     = (next_sel <= sel);
  assign commit   = tick && any_ch && wrap && (pending || update);
  assign ch_valid = ch_mask[sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      sel        <= '0;
      data_bus   <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      committed  <= 1'b0;
      for (int i = 0; i < SIZE_M; i++) shadow[i] <= '0;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick && any_ch) sel <= next_sel;
      frame_done <= tick && any_ch && wrap;
      committed  <= commit;
      // Active bank takes the pre-edge shadow; a same-edge write lands in shadow only.
      if (commit) begin
        for (int i = 0; i < SIZE_M; i++) data_bus[i*SIZE_N +: SIZE_N] <= shadow[i];
      end
      if (wr_en) shadow[wr_addr] <= wr_data;
      if (commit) pending <= 1'b0;
      else if (update) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: per-cycle reference model feeding a scoreboard queue,
// phase table with hand-derived end states, and a DIV=1 instance.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, wr_en, update;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  ch_mask;
  logic [1:0]  sel;
  logic [31:0] data_bus;
  logic        ch_valid, frame_done, committed;

  logic        rst1;
  logic [1:0]  sel1;
  logic [31:0] bus1;
  logic        valid1, fd1, cm1;

  always #5 clk = ~clk;

  mux_scan_ctrl #(.SIZE_SEL(2), .SIZE_M(4), .SIZE_N(8), .DIV(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .update(update), .ch_mask(ch_mask), .sel(sel), .data_bus(data_bus),
    .ch_valid(ch_valid), .frame_done(frame_done), .committed(committed)
  );

  mux_scan_ctrl #(.SIZE_SEL(2), .SIZE_M(4), .SIZE_N(8), .DIV(1), .DIV_W(4)) dut1 (
    .clk(clk), .rst(rst1), .en(1'b1), .wr_en(1'b0), .wr_addr(2'd0), .wr_data(8'd0),
    .update(1'b0), .ch_mask(4'b1111), .sel(sel1), .data_bus(bus1),
    .ch_valid(valid1), .frame_done(fd1), .committed(cm1)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] bus;
    logic        fd;
    logic        cm;
    logic        vld;
  } obs_t;

  typedef struct {
    bit        rst;
    bit        en;
    bit        wr;
    bit [1:0]  addr;
    bit [7:0]  data;
    bit        upd;
    bit [3:0]  mask;
    int        n;
    bit [1:0]  esel;
    bit [31:0] ebus;
    int        efd;
    int        ecm;
  } vec_t;

  obs_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state
  int       m_cnt, m_sel, m_pend;
  bit [7:0] m_sh [4];
  bit [7:0] m_act [4];
  bit       m_fd, m_cm;

  function automatic obs_t model_obs();
    obs_t o;
    o.sel = 2'(m_sel);
    o.bus = {m_act[3], m_act[2], m_act[1], m_act[0]};
    o.fd  = m_fd;
    o.cm  = m_cm;
    o.vld = ch_mask[m_sel];
    return o;
  endfunction

  task automatic model_edge();
    bit tick, wrapped;
    int ns;
    if (rst) begin
      m_cnt = 0; m_sel = 0; m_pend = 0; m_fd = 0; m_cm = 0;
      for (int i = 0; i < 4; i++) begin m_sh[i] = 8'h00; m_act[i] = 8'h00; end
      return;
    end
    tick = en && (m_cnt == 3);
    if (en) m_cnt = tick ? 0 : m_cnt + 1;
    wrapped = 1'b0;
    ns = m_sel;
    if (tick && ch_mask != 4'b0000) begin
      ns = (m_sel + 1) % 4;
      while (!ch_mask[ns]) ns = (ns + 1) % 4;
      wrapped = (ns <= m_sel);
    end
    m_fd = wrapped;
    m_cm = wrapped && (m_pend != 0 || update);
    if (m_cm) for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
    if (m_cm) m_pend = 0;
    else if (update) m_pend = 1;
    if (wr_en) m_sh[wr_addr] = wr_data;
    m_sel = ns;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: model pushes its expectation, DUT result popped and compared after the edge.
  task automatic step(output bit fd_seen, output bit cm_seen);
    obs_t e, a;
    model_edge();
    q.push_back(model_obs());
    @(posedge clk);
    #1;
    a = '{sel: sel, bus: data_bus, fd: frame_done, cm: committed, vld: ch_valid};
    e = q.pop_front();
    check("cycle", 64'(a), 64'(e));
    fd_seen = a.fd;
    cm_seen = a.cm;
  endtask

  vec_t vt[$];

  initial begin
    bit f, c;
    int nfd, ncm;
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
    update = 1'b0; ch_mask = 4'hF; rst1 = 1'b1;

    //          rst en wr addr data  upd mask  n  esel ebus          efd ecm
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'hF, 16, 2'd0, 32'h00000000, 1, 0}); // A
    vt.push_back('{0, 1, 1, 2'd2, 8'hA5, 1, 4'hF,  1, 2'd0, 32'h00000000, 0, 0}); // B
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'hF, 14, 2'd3, 32'h00000000, 0, 0}); // C
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'hF,  1, 2'd0, 32'h00A50000, 1, 1}); // D
    vt.push_back('{0, 1, 1, 2'd1, 8'h77, 1, 4'hF,  1, 2'd0, 32'h00A50000, 0, 0}); // E
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'hF, 14, 2'd3, 32'h00A50000, 0, 0}); // F
    vt.push_back('{0, 1, 1, 2'd1, 8'h3C, 1, 4'hF,  1, 2'd0, 32'h00A57700, 1, 1}); // G
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'hF, 16, 2'd0, 32'h00A57700, 1, 0}); // H
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 1, 4'hF,  1, 2'd0, 32'h00A57700, 0, 0}); // I
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'hF, 15, 2'd0, 32'h00A53C00, 1, 1}); // J
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'h5, 16, 2'd0, 32'h00A53C00, 2, 0}); // K
    vt.push_back('{0, 1, 1, 2'd0, 8'h11, 1, 4'h0,  1, 2'd0, 32'h00A53C00, 0, 0}); // L
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'h0, 12, 2'd0, 32'h00A53C00, 0, 0}); // M
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'hF, 15, 2'd0, 32'h00A53C11, 1, 1}); // N
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'hF,  6, 2'd1, 32'h00A53C11, 0, 0}); // O
    vt.push_back('{0, 0, 0, 2'd0, 8'h00, 0, 4'hF, 10, 2'd1, 32'h00A53C11, 0, 0}); // P
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'hF,  2, 2'd2, 32'h00A53C11, 0, 0}); // Q
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 1, 4'hF,  1, 2'd2, 32'h00A53C11, 0, 0}); // R
    vt.push_back('{1, 1, 0, 2'd0, 8'h00, 0, 4'hF,  1, 2'd0, 32'h00000000, 0, 0}); // reset
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'hF, 16, 2'd0, 32'h00000000, 1, 0}); // S
    vt.push_back('{0, 1, 0, 2'd0, 8'h00, 0, 4'h4, 12, 2'd2, 32'h00000000, 2, 0}); // T

    step(f, c);
    step(f, c);
    check("reset_sel", 64'(sel), 64'd0);
    check("reset_bus", 64'(data_bus), 64'd0);
    check("reset_pulses", 64'({frame_done, committed}), 64'd0);
    rst = 1'b0;

    for (int p = 0; p < vt.size(); p++) begin
      rst = vt[p].rst; en = vt[p].en; wr_en = vt[p].wr; wr_addr = vt[p].addr;
      wr_data = vt[p].data; update = vt[p].upd; ch_mask = vt[p].mask;
      nfd = 0; ncm = 0;
      for (int i = 0; i < vt[p].n; i++) begin
        step(f, c);
        nfd += int'(f);
        ncm += int'(c);
        if (vt[p].mask == 4'h0) check("nomask_valid", 64'(ch_valid), 64'd0);
      end
      check($sformatf("ph%0d_sel", p), 64'(sel), 64'(vt[p].esel));
      check($sformatf("ph%0d_bus", p), 64'(data_bus), 64'(vt[p].ebus));
      check($sformatf("ph%0d_fd", p), 64'(nfd), 64'(vt[p].efd));
      check($sformatf("ph%0d_cm", p), 64'(ncm), 64'(vt[p].ecm));
    end
    rst = 1'b0; wr_en = 1'b0; update = 1'b0;

    // DIV=1: tick on every cycle, frame_done on each 3->0 step.
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    check("div1_reset", 64'(sel1), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("div1_sel%0d", k), 64'(sel1), 64'(k % 4));
      check($sformatf("div1_fd%0d", k), 64'(fd1), 64'((k % 4) == 0));
    end

    if (q.size() != 0) check("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
